// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through FIFO.
// Framing errors and overruns are reported in sticky flags cleared by clr_err.
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rxd,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     overrun,
    input  logic                     clr_err
);

    localparam int unsigned DIV   = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    logic [1:0]       sync_q;
    logic             rxs;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    state_e           state_q, state_d;
    logic [3:0]       tc_q, tc_d;
    logic [2:0]       bi_q, bi_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic [7:0]       push_data_q, push_data_d;
    logic             frame_set;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, pop, wr_en, ovf_set;
    logic             frame_err_q, overrun_q;

    assign rxs  = sync_q[1];
    assign tick = (div_q == DIV_W'(DIV - 1));

    // Divider restarts on the start edge so ticks are phase-aligned to the frame.
    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (state_q == StIdle && !rxs) div_d = '0;
    end

    always_comb begin
        state_d     = state_q;
        tc_d        = tc_q;
        bi_d        = bi_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        frame_set   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rxs) begin
                    state_d = StStart;
                    tc_d    = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (tc_q == 4'd7) begin
                        if (rxs) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            tc_d    = '0;
                            bi_d    = '0;
                        end
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    tc_d = tc_q + 4'd1;
                    if (tc_q == 4'd15) begin
                        shift_d[bi_q] = rxs;
                        if (bi_q == 3'd7) state_d = StStop;
                        else              bi_d    = bi_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    tc_d = tc_q + 4'd1;
                    if (tc_q == 4'd15) begin
                        if (rxs) begin
                            push_d      = 1'b1;
                            push_data_d = shift_q;
                            state_d     = StIdle;
                        end else begin
                            frame_set = 1'b1;
                            state_d   = StWaitHigh;
                        end
                    end
                end
            end
            StWaitHigh: begin
                if (rxs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= 2'b11;
            div_q       <= '0;
            state_q     <= StIdle;
            tc_q        <= '0;
            bi_q        <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            sync_q      <= {sync_q[0], rxd};
            div_q       <= div_d;
            state_q     <= state_d;
            tc_q        <= tc_d;
            bi_q        <= bi_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && rd_ready;
    assign full     = (count_q == CW'(DEPTH));
    // When full, a same-cycle pop frees the head slot, which wr_ptr aliases.
    assign wr_en    = push_q && (!full || pop);
    assign ovf_set  = push_q && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= push_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_en && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !wr_en) count_q <= count_q - CW'(1);
            frame_err_q <= frame_set | (frame_err_q & ~clr_err);
            overrun_q   <= ovf_set | (overrun_q & ~clr_err);
        end
    end

    assign rd_data   = rd_valid ? mem[rd_ptr_q] : 8'h00;
    assign count     = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes are queued when frames are sent
// and a negedge monitor checks every accepted pop against the queue head.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 10_000;
    localparam int unsigned DEPTH  = 16;
    localparam int BIT_CLKS = 160;
    // Start-edge drive to write cycle: 2 sync flops + IDLE exit, then 8 + 9*16 ticks of 10 clk.
    localparam int PUSH_CLKS = 3 + 10 * (8 + 9 * 16);

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rxd;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] count;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] exp_q[$];
    bit rand_on;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rxd      (rxd),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .frame_err(frame_err),
        .overrun  (overrun),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            wait_clk(BIT_CLKS);
        end
    endtask

    // Reference FIFO: a byte joins the expected stream unless the FIFO would be full
    // with no pop in the same cycle.
    task automatic model_push(input logic [7:0] b, input bit pop_same_cycle, output bit dropped);
        dropped = (exp_q.size() >= DEPTH) && !pop_same_cycle;
        if (!dropped) exp_q.push_back(b);
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        wait_clk(n);
        rd_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data", rd_data);
            end else begin
                check("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        bit dropped;
        logic [7:0] b;
        reset_n  = 1'b0;
        rxd      = 1'b1;
        rd_ready = 1'b0;
        clr_err  = 1'b0;
        wait_clk(5);
        check("rst_valid", rd_valid, 0);
        check("rst_count", count, 0);
        check("rst_data", rd_data, 0);
        reset_n = 1'b1;

        wait_clk(2000);
        check("idle_valid", rd_valid, 0);
        check("idle_count", count, 0);
        check("idle_ferr", frame_err, 0);
        check("idle_ovr", overrun, 0);

        model_push(8'hA5, 1'b0, dropped);
        send_frame(8'hA5, 1'b1);
        wait_clk(4);
        check("a5_valid", rd_valid, 1);
        check("a5_data", rd_data, 8'hA5);
        check("a5_count", count, 1);
        drain(1);
        check("a5_pop_count", count, 0);
        check("a5_pop_valid", rd_valid, 0);

        rxd = 1'b0;
        wait_clk(50);
        rxd = 1'b1;
        wait_clk(200);
        check("glitch_count", count, 0);
        check("glitch_ferr", frame_err, 0);

        send_frame(8'h3C, 1'b0);
        rxd = 1'b0;
        wait_clk(500);
        rxd = 1'b1;
        wait_clk(20);
        model_push(8'h11, 1'b0, dropped);
        send_frame(8'h11, 1'b1);
        wait_clk(4);
        check("ferr_set", frame_err, 1);
        check("ferr_count", count, 1);
        drain(3);
        check("ferr_drained", count, 0);
        clr_err = 1'b1;
        wait_clk(1);
        clr_err = 1'b0;
        wait_clk(1);
        check("ferr_clr", frame_err, 0);

        for (int i = 0; i < 17; i++) begin
            model_push(8'(i), 1'b0, dropped);
            send_frame(8'(i), 1'b1);
        end
        wait_clk(4);
        check("ovr_count", count, exp_q.size());
        check("ovr_set", overrun, {31'h0, dropped});
        clr_err = 1'b1;
        wait_clk(1);
        clr_err = 1'b0;
        wait_clk(1);
        check("ovr_clr", overrun, 0);

        model_push(8'h40, 1'b1, dropped);
        fork
            send_frame(8'h40, 1'b1);
            begin
                wait_clk(PUSH_CLKS);
                rd_ready = 1'b1;
                wait_clk(1);
                rd_ready = 1'b0;
            end
        join
        wait_clk(4);
        check("fullpop_count", count, 16);
        check("fullpop_ovr", overrun, 0);
        drain(30);
        check("fullpop_drained_valid", rd_valid, 0);
        check("fullpop_drained_count", count, 0);

        rand_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    b = 8'($urandom_range(0, 255));
                    model_push(b, 1'b0, dropped);
                    send_frame(b, 1'b1);
                    wait_clk($urandom_range(0, 40));
                end
                wait_clk(10);
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    rd_ready = 1'($urandom_range(0, 1));
                    wait_clk(1);
                end
                rd_ready = 1'b0;
            end
        join
        drain(20);
        check("rand_drained", count, 0);
        check("rand_sb_empty", exp_q.size(), 0);

        model_push(8'h77, 1'b0, dropped);
        send_frame(8'h77, 1'b1);
        send_frame(8'h55, 1'b0);
        rxd = 1'b1;
        wait_clk(20);
        rxd = 1'b0;
        wait_clk(700);
        check("pre_rst_count", count, 1);
        check("pre_rst_ferr", frame_err, 1);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
        rxd = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(50);
        model_push(8'hC3, 1'b0, dropped);
        send_frame(8'hC3, 1'b1);
        wait_clk(4);
        check("post_rst_count", count, 1);
        check("post_rst_data", rd_data, 8'hC3);
        drain(3);
        check("final_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
